// File: rtl/csa_arbiter_if.sv
// Requester/consumer bundle for the shared carry-select adder arbiter.
// master = requesters + response consumer, slave = the arbiter.
interface csa_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) ();
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ-1:0]    req_cin;
  logic [NREQ-1:0]    req_wide;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [31:0]        rsp_sum;
  logic               rsp_cout;

  modport master (
    output req_valid, req_a, req_b, req_cin, req_wide, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, req_wide, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );
endinterface

// File: rtl/csa_arbiter.sv
// Round-robin arbiter sharing one external 16-bit adder between NREQ
// requesters. Narrow ops take one adder pass, wide ops take two with the
// low-half carry chained into the high pass.
//
// state | meaning
// IDLE  | search for a requester from the pointer, grant and latch operands
// LO    | low-half pass on the adder
// HI    | high-half pass, carry-in from the LO pass (wide ops only)
// OUT   | hold the response until the consumer takes it
module csa_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  csa_arbiter_if.slave bus,
  output logic [15:0]  add_a_o,
  output logic [15:0]  add_b_o,
  output logic         add_cin_o,
  input  logic [15:0]  add_sum_i,
  input  logic         add_cout_i
);

  typedef enum logic [1:0] {IDLE, LO, HI, OUT} state_t;

  localparam int            NSLOT  = 2 ** IDW;
  localparam logic [IDW:0]  NREQ_W = (IDW + 1)'(NREQ);
  localparam logic [IDW-1:0] LAST  = IDW'(NREQ - 1);

  state_t          state_q;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  ptr_d;
  logic [31:0]     a_q;
  logic [31:0]     b_q;
  logic            cin_q;
  logic            wide_q;
  logic [IDW-1:0]  id_q;
  logic [15:0]     sum_lo_q;
  logic            c_q;
  logic            rsp_valid_q;
  logic [31:0]     rsp_sum_q;
  logic            rsp_cout_q;

  logic [NSLOT-1:0] valid_ext;
  logic [NSLOT-1:0] ready_ext;
  logic [IDW:0]     scan_idx;
  logic             gnt_found;
  logic [IDW-1:0]   gnt_idx;
  logic [31:0]      sel_a;
  logic [31:0]      sel_b;
  logic             sel_cin;
  logic             sel_wide;

  // Round-robin search starting at the pointer, wrapping at NREQ.
  always_comb begin
    valid_ext = '0;
    valid_ext[NREQ-1:0] = bus.req_valid;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = {1'b0, ptr_q} + (IDW + 1)'(k);
      if (scan_idx >= NREQ_W) scan_idx = scan_idx - NREQ_W;
      if (!gnt_found && valid_ext[scan_idx[IDW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx[IDW-1:0];
      end
    end
    ptr_d = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    sel_cin  = 1'b0;
    sel_wide = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        sel_a    = bus.req_a[32*i +: 32];
        sel_b    = bus.req_b[32*i +: 32];
        sel_cin  = bus.req_cin[i];
        sel_wide = bus.req_wide[i];
      end
    end
  end

  // Accept strobe only in IDLE; held off while reset is asserted so no
  // handshake can complete on a reset edge.
  always_comb begin
    ready_ext = '0;
    if (state_q == IDLE && rst_n && gnt_found) ready_ext[gnt_idx] = 1'b1;
    bus.req_ready = ready_ext[NREQ-1:0];
  end

  // Adder operands: low half in LO, high half with chained carry in HI.
  always_comb begin
    add_a_o   = '0;
    add_b_o   = '0;
    add_cin_o = 1'b0;
    case (state_q)
      LO: begin
        add_a_o   = a_q[15:0];
        add_b_o   = b_q[15:0];
        add_cin_o = cin_q;
      end
      HI: begin
        add_a_o   = a_q[31:16];
        add_b_o   = b_q[31:16];
        add_cin_o = c_q;
      end
      default: ;
    endcase
  end

  // Transaction FSM with registered response outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      wide_q      <= 1'b0;
      id_q        <= '0;
      sum_lo_q    <= '0;
      c_q         <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_found) begin
            a_q     <= sel_a;
            b_q     <= sel_b;
            cin_q   <= sel_cin;
            wide_q  <= sel_wide;
            id_q    <= gnt_idx;
            ptr_q   <= ptr_d;
            state_q <= LO;
          end
        end
        LO: begin
          sum_lo_q <= add_sum_i;
          c_q      <= add_cout_i;
          if (wide_q) begin
            state_q <= HI;
          end else begin
            rsp_sum_q   <= {16'h0000, add_sum_i};
            rsp_cout_q  <= add_cout_i;
            rsp_valid_q <= 1'b1;
            state_q     <= OUT;
          end
        end
        HI: begin
          rsp_sum_q   <= {add_sum_i, sum_lo_q};
          rsp_cout_q  <= add_cout_i;
          rsp_valid_q <= 1'b1;
          state_q     <= OUT;
        end
        OUT: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_cout  = rsp_cout_q;

endmodule

// File: tb/tb_csa_arbiter.sv
// Directed bench for csa_arbiter with a behavioural 16-bit adder.
module tb_csa_arbiter;

  logic        clk;
  logic        rst_n;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic        add_cin;
  logic [15:0] add_sum;
  logic        add_cout;

  int n_chk  = 0;
  int n_pass = 0;

  csa_arbiter_if #(.NREQ(4), .IDW(2)) bus ();

  csa_arbiter #(.NREQ(4), .IDW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .add_a_o   (add_a),
    .add_b_o   (add_b),
    .add_cin_o (add_cin),
    .add_sum_i (add_sum),
    .add_cout_i(add_cout)
  );

  // External adder
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'h0000, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic wide);
    bus.req_a[32*i +: 32] = a;
    bus.req_b[32*i +: 32] = b;
    bus.req_cin[i]        = cin;
    bus.req_wide[i]       = wide;
  endtask

  int exp_id [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = '0;
    bus.req_wide  = '0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // Reset state, with a pending request that must not be accepted
    set_req(0, 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0);
    bus.req_valid[0] = 1'b1;
    #1;
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_sum", bus.rsp_sum, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_rsp_cout", bus.rsp_cout, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    chk("rst_add_cin", add_cin, 0);

    // Narrow overflow, requester 0
    @(negedge clk); rst_n = 1'b1; #1;
    chk("n_grant", bus.req_ready, 4'b0001);
    chk("n_idle_add_a", add_a, 0);
    @(negedge clk); bus.req_valid[0] = 1'b0; #1;
    chk("n_lo_add_a", add_a, 16'hFFFF);
    chk("n_lo_add_b", add_b, 16'h0001);
    chk("n_lo_add_cin", add_cin, 0);
    chk("n_lo_ready", bus.req_ready, 0);
    chk("n_lo_rsp_valid", bus.rsp_valid, 0);
    @(negedge clk); #1;
    chk("n_rsp_valid", bus.rsp_valid, 1);
    chk("n_rsp_id", bus.rsp_id, 0);
    chk("n_rsp_sum", bus.rsp_sum, 32'h00000000);
    chk("n_rsp_cout", bus.rsp_cout, 1);
    chk("n_out_add_a", add_a, 0);

    // Wide carry chain, requester 1
    @(negedge clk);
    set_req(1, 32'h0000FFFF, 32'h00000001, 1'b0, 1'b1);
    bus.req_valid[1] = 1'b1;
    #1;
    chk("n_rsp_drop", bus.rsp_valid, 0);
    chk("w_grant", bus.req_ready, 4'b0010);
    @(negedge clk); bus.req_valid[1] = 1'b0; #1;
    chk("w_lo_add_a", add_a, 16'hFFFF);
    chk("w_lo_add_cin", add_cin, 0);
    @(negedge clk); #1;
    chk("w_hi_add_a", add_a, 16'h0000);
    chk("w_hi_add_b", add_b, 16'h0000);
    chk("w_hi_add_cin", add_cin, 1);
    chk("w_hi_rsp_valid", bus.rsp_valid, 0);
    @(negedge clk); #1;
    chk("w_rsp_valid", bus.rsp_valid, 1);
    chk("w_rsp_id", bus.rsp_id, 1);
    chk("w_rsp_sum", bus.rsp_sum, 32'h00010000);
    chk("w_rsp_cout", bus.rsp_cout, 0);

    // Wide full wrap, requester 2
    @(negedge clk);
    set_req(2, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1);
    bus.req_valid[2] = 1'b1;
    #1;
    chk("wf_grant", bus.req_ready, 4'b0100);
    @(negedge clk); bus.req_valid[2] = 1'b0; #1;
    chk("wf_lo_add_cin", add_cin, 1);
    @(negedge clk); #1;
    chk("wf_hi_add_a", add_a, 16'hFFFF);
    chk("wf_hi_add_cin", add_cin, 1);
    @(negedge clk); #1;
    chk("wf_rsp_id", bus.rsp_id, 2);
    chk("wf_rsp_sum", bus.rsp_sum, 32'h00000000);
    chk("wf_rsp_cout", bus.rsp_cout, 1);

    // Narrow op ignores upper operand halves, requester 3
    @(negedge clk);
    set_req(3, 32'hABCD0001, 32'h12340002, 1'b0, 1'b0);
    bus.req_valid[3] = 1'b1;
    #1;
    chk("nu_grant", bus.req_ready, 4'b1000);
    @(negedge clk); bus.req_valid[3] = 1'b0; #1;
    chk("nu_lo_add_a", add_a, 16'h0001);
    chk("nu_lo_add_b", add_b, 16'h0002);
    @(negedge clk); #1;
    chk("nu_rsp_id", bus.rsp_id, 3);
    chk("nu_rsp_sum", bus.rsp_sum, 32'h00000003);
    chk("nu_rsp_cout", bus.rsp_cout, 0);

    // Round robin with all requesters persistent
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (n == 0) begin
        for (int i = 0; i < 4; i++) set_req(i, 32'(i), 32'h10, 1'b0, 1'b0);
        bus.req_valid = 4'b1111;
      end
      #1;
      chk("rr_idle_rsp_valid", bus.rsp_valid, 0);
      chk("rr_grant", bus.req_ready, 32'(1) << exp_id[n]);
      @(negedge clk); #1;
      chk("rr_lo_ready", bus.req_ready, 0);
      @(negedge clk);
      if (n == 4) bus.req_valid = '0;
      #1;
      chk("rr_out_ready", bus.req_ready, 0);
      chk("rr_rsp_valid", bus.rsp_valid, 1);
      chk("rr_rsp_id", bus.rsp_id, 32'(exp_id[n]));
      chk("rr_rsp_sum", bus.rsp_sum, 32'h10 + 32'(exp_id[n]));
    end
    @(negedge clk); #1;
    chk("rr_end_rsp_valid", bus.rsp_valid, 0);
    chk("rr_end_ready", bus.req_ready, 0);
    @(negedge clk); #1;
    chk("idle_no_req_ready", bus.req_ready, 0);

    // Backpressure: pointer is 1, requester 3 is the only one valid
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    set_req(3, 32'h00000100, 32'h00000023, 1'b0, 1'b0);
    bus.req_valid[3] = 1'b1;
    #1;
    chk("bp_grant", bus.req_ready, 4'b1000);
    @(negedge clk);
    bus.req_valid[3] = 1'b0;
    set_req(1, 32'h00000005, 32'h00000006, 1'b0, 1'b0);
    bus.req_valid[1] = 1'b1;
    #1;
    chk("bp_lo_ready", bus.req_ready, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      chk("bp_hold_valid", bus.rsp_valid, 1);
      chk("bp_hold_sum", bus.rsp_sum, 32'h00000123);
      chk("bp_hold_id", bus.rsp_id, 3);
      chk("bp_hold_ready", bus.req_ready, 0);
    end
    @(negedge clk); bus.rsp_ready = 1'b1; #1;
    chk("bp_release_valid", bus.rsp_valid, 1);
    chk("bp_release_sum", bus.rsp_sum, 32'h00000123);
    @(negedge clk); #1;
    chk("bp_after_valid", bus.rsp_valid, 0);
    chk("bp_next_grant", bus.req_ready, 4'b0010);
    @(negedge clk); bus.req_valid[1] = 1'b0; #1;
    chk("bp_next_add_a", add_a, 16'h0005);
    @(negedge clk); #1;
    chk("bp_next_rsp_id", bus.rsp_id, 1);
    chk("bp_next_rsp_sum", bus.rsp_sum, 32'h0000000B);

    // Reset during HI of a wide op on requester 2
    @(negedge clk);
    set_req(2, 32'h00010002, 32'h00030004, 1'b0, 1'b1);
    bus.req_valid[2] = 1'b1;
    #1;
    chk("rm_grant", bus.req_ready, 4'b0100);
    @(negedge clk); bus.req_valid[2] = 1'b0; #1;
    chk("rm_lo_add_a", add_a, 16'h0002);
    @(negedge clk); #1;
    chk("rm_hi_add_a", add_a, 16'h0001);
    chk("rm_hi_add_b", add_b, 16'h0003);
    rst_n = 1'b0;
    @(negedge clk); #1;
    chk("rm_rst_rsp_valid", bus.rsp_valid, 0);
    chk("rm_rst_add_a", add_a, 0);
    set_req(0, 32'h00000007, 32'h00000008, 1'b1, 1'b0);
    bus.req_valid = 4'b0101;
    #1;
    chk("rm_rst_ready", bus.req_ready, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rm_ptr0_grant", bus.req_ready, 4'b0001);
    chk("rm_idle_rsp_valid", bus.rsp_valid, 0);
    @(negedge clk); bus.req_valid[0] = 1'b0; #1;
    chk("rm_lo_rsp_valid", bus.rsp_valid, 0);
    chk("rm_lo_add_cin", add_cin, 1);
    @(negedge clk); #1;
    chk("rm_r0_valid", bus.rsp_valid, 1);
    chk("rm_r0_id", bus.rsp_id, 0);
    chk("rm_r0_sum", bus.rsp_sum, 32'h00000010);
    @(negedge clk); #1;
    chk("rm_r0_drop", bus.rsp_valid, 0);
    chk("rm_r2_grant", bus.req_ready, 4'b0100);
    @(negedge clk); bus.req_valid[2] = 1'b0; #1;
    chk("rm_r2_lo_valid", bus.rsp_valid, 0);
    @(negedge clk); #1;
    chk("rm_r2_hi_valid", bus.rsp_valid, 0);
    chk("rm_r2_hi_add_cin", add_cin, 0);
    @(negedge clk); #1;
    chk("rm_r2_valid", bus.rsp_valid, 1);
    chk("rm_r2_id", bus.rsp_id, 2);
    chk("rm_r2_sum", bus.rsp_sum, 32'h00040006);
    chk("rm_r2_cout", bus.rsp_cout, 0);
    @(negedge clk); #1;
    chk("rm_r2_drop", bus.rsp_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
